// File: rtl/inst_fetch_queue_if.sv
// Fetch-stage bundle: redirect input, instruction-memory handshake,
// decode-side valid/ready queue head and the misalignment flag.
interface inst_fetch_queue_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int INST_WIDTH = 32
) ();
   logic                  redirect;
   logic [ADDR_WIDTH-1:0] redirect_pc;
   logic                  mem_req;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_ack;
   logic                  mem_rvalid;
   logic [INST_WIDTH-1:0] mem_rdata;
   logic                  inst_valid;
   logic [INST_WIDTH-1:0] inst;
   logic [ADDR_WIDTH-1:0] inst_pc;
   logic                  inst_ready;
   logic                  misalign_err;

   modport master (
      input  redirect, redirect_pc,
      input  mem_ack, mem_rvalid, mem_rdata,
      input  inst_ready,
      output mem_req, mem_addr,
      output inst_valid, inst, inst_pc,
      output misalign_err
   );

   modport slave (
      output redirect, redirect_pc,
      output mem_ack, mem_rvalid, mem_rdata,
      output inst_ready,
      input  mem_req, mem_addr,
      input  inst_valid, inst, inst_pc,
      input  misalign_err
   );
endinterface

// File: rtl/inst_fetch_queue.sv
// Sequential instruction fetch with a small PC/instruction queue.
// Optional FETCH_ALIGN_CHECK_EN: word-align redirects, flag misalignment.
module inst_fetch_queue #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    INST_WIDTH = 32,
   parameter int                    DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input logic                 clk,
   input logic                 rst,
   inst_fetch_queue_if.master  bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [2:0] {
      IDLE, REQ, WAIT, REQ_STALE, WAIT_STALE
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic                  err_q, err_d;
   logic [INST_WIDTH-1:0] inst_q [DEPTH];
   logic [ADDR_WIDTH-1:0] pc_q   [DEPTH];

   logic                  push, pop, mis;
   logic [CW-1:0]         cnt_after;
   logic [ADDR_WIDTH-1:0] tgt;

`ifdef FETCH_ALIGN_CHECK_EN
   assign tgt = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
   assign mis = |bus.redirect_pc[1:0];
`else
   assign tgt = bus.redirect_pc;
   assign mis = 1'b0;
`endif

   assign bus.inst_valid   = (count_q != '0);
   assign bus.inst         = inst_q[rd_ptr_q];
   assign bus.inst_pc      = pc_q[rd_ptr_q];
   assign bus.mem_req      = (state_q == REQ) || (state_q == REQ_STALE);
   // A stale request keeps presenting the pre-redirect address until acked
   assign bus.mem_addr     = (state_q == REQ_STALE) ? req_addr_q
                                                    : fetch_pc_q;
   assign bus.misalign_err = err_q;

   assign pop       = bus.inst_valid && bus.inst_ready;
   assign push      = (state_q == WAIT) && bus.mem_rvalid
                      && !bus.redirect;
   assign cnt_after = count_q + CW'(push) - CW'(pop);

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_addr_d = req_addr_q;
      count_d    = cnt_after;
      rd_ptr_d   = rd_ptr_q + PW'(pop);
      wr_ptr_d   = wr_ptr_q + PW'(push);
      err_d      = err_q;

      if (state_q == REQ) req_addr_d = fetch_pc_q;

      unique case (state_q)
         IDLE: begin
            if (count_q < CW'(DEPTH)) state_d = REQ;
         end
         REQ: begin
            if (bus.mem_ack) begin
               state_d    = WAIT;
               fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
            end
         end
         WAIT: begin
            if (bus.mem_rvalid)
               state_d = (cnt_after < CW'(DEPTH - 1)) ? REQ : IDLE;
         end
         REQ_STALE: begin
            if (bus.mem_ack) state_d = WAIT_STALE;
         end
         WAIT_STALE: begin
            if (bus.mem_rvalid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (bus.redirect) begin
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         fetch_pc_d = tgt;
         err_d      = err_q | mis;
         unique case (state_q)
            IDLE:    state_d = IDLE;
            REQ:     state_d = bus.mem_ack ? WAIT_STALE : REQ_STALE;
            WAIT:    state_d = bus.mem_rvalid ? IDLE : WAIT_STALE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         req_addr_q <= RESET_PC;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_addr_q <= req_addr_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         err_q      <= err_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            inst_q[i] <= '0;
            pc_q[i]   <= '0;
         end
      end else if (push) begin
         inst_q[wr_ptr_q] <= bus.mem_rdata;
         pc_q[wr_ptr_q]   <= req_addr_q;
      end
   end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized bench for inst_fetch_queue against a queue-level model,
// plus directed scenarios pinned with literal expectations.
module tb_inst_fetch_queue;

   localparam int          AW       = 32;
   localparam int          IW       = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   inst_fetch_queue_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) bus ();

   inst_fetch_queue #(
      .ADDR_WIDTH(AW), .INST_WIDTH(IW),
      .DEPTH(DEPTH), .RESET_PC(RESET_PC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   int n_vec = 0;
   int n_err = 0;

   // model: queue contents plus request/outstanding/stale flags
   ent_t        mq[$];
   logic [31:0] m_pc, m_raddr;
   bit          m_req, m_out, m_stale, m_err;
   logic [31:0] acks_log[$];
   logic [31:0] pops_log[$];

   // memory responder
   bit          mb;
   int          md;
   logic [31:0] ma;

   int ack_pct, dmax, rdy_pct, redir_pct, ack_hold;
   int cyc_idx, first_req, first_val;

   function automatic logic [31:0] rdata_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
   endfunction

   function automatic logic [31:0] rand_tgt();
      int s;
      s = $urandom_range(9);
      if (s == 0) return 32'hFFFF_FFF8;
      if (s == 1) return $urandom & 32'h0000_FFFF;
      return $urandom & 32'h0000_FFFC;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit rd, input logic [31:0] rp,
                             input bit ak, input bit rv,
                             input logic [31:0] dat, input bit ry);
      int   sz0;
      bit   pp;
      ent_t e;
      sz0 = mq.size();
      pp  = (sz0 != 0) && ry;
      if (pp) pops_log.push_back(mq[0].pc);
      if (rd) begin
         mq.delete();
         m_pc = ALIGN_EN ? (rp & 32'hFFFF_FFFC) : rp;
         if (ALIGN_EN && rp[1:0] != 2'b00) m_err = 1'b1;
         if (m_req) begin
            m_stale = 1'b1;
            if (ak) begin
               acks_log.push_back(m_raddr);
               m_req = 1'b0;
               m_out = 1'b1;
            end
         end else if (m_out) begin
            if (rv) begin
               m_out   = 1'b0;
               m_stale = 1'b0;
            end else begin
               m_stale = 1'b1;
            end
         end
      end else begin
         if (pp) void'(mq.pop_front());
         if (m_req) begin
            if (ak) begin
               acks_log.push_back(m_raddr);
               m_req = 1'b0;
               m_out = 1'b1;
               if (!m_stale) m_pc = m_pc + 32'd4;
            end
         end else if (m_out) begin
            if (rv) begin
               m_out = 1'b0;
               if (m_stale) begin
                  m_stale = 1'b0;
               end else begin
                  e.pc  = m_raddr;
                  e.ins = dat;
                  mq.push_back(e);
                  if (mq.size() < DEPTH - 1) begin
                     m_req   = 1'b1;
                     m_raddr = m_pc;
                  end
               end
            end
         end else if (sz0 < DEPTH) begin
            m_req   = 1'b1;
            m_raddr = m_pc;
         end
      end
   endtask

   task automatic check_outputs();
      chk("inst_valid", bus.inst_valid, 32'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk("inst", bus.inst, mq[0].ins);
         chk("inst_pc", bus.inst_pc, mq[0].pc);
      end
      chk("mem_req", bus.mem_req, 32'(m_req));
      if (m_req) chk("mem_addr", bus.mem_addr, m_raddr);
      chk("misalign_err", bus.misalign_err, 32'(m_err));
   endtask

   task automatic cycle(input bit fr, input logic [31:0] frpc);
      bit          rd, ak, rv, ry;
      logic [31:0] rp, dat, addr_now;
      rd = fr || ($urandom_range(99) < redir_pct);
      rp = fr ? frpc : rand_tgt();
      ry = ($urandom_range(99) < rdy_pct);
      rv = mb && (md == 0);
      ak = bus.mem_req && !mb && (ack_hold == 0)
           && ($urandom_range(99) < ack_pct);
      if (ack_hold > 0) ack_hold--;
      dat      = rv ? rdata_of(ma) : $urandom;
      addr_now = bus.mem_addr;
      bus.redirect    = rd;
      bus.redirect_pc = rp;
      bus.inst_ready  = ry;
      bus.mem_ack     = ak;
      bus.mem_rvalid  = rv;
      bus.mem_rdata   = dat;
      @(posedge clk);
      model_step(rd, rp, ak, rv, dat, ry);
      if (rv) mb = 1'b0;
      else if (mb && md > 0) md--;
      if (ak) begin
         mb = 1'b1;
         ma = addr_now;
         md = $urandom_range(dmax);
      end
      @(negedge clk);
      if (m_req && first_req < 0) first_req = cyc_idx;
      if (mq.size() != 0 && first_val < 0) first_val = cyc_idx;
      cyc_idx++;
      check_outputs();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 32'h0);
   endtask

   task automatic do_reset();
      rst             = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.inst_ready  = 1'b0;
      bus.mem_ack     = 1'b0;
      bus.mem_rvalid  = 1'b0;
      bus.mem_rdata   = '0;
      mq.delete();
      acks_log.delete();
      pops_log.delete();
      m_pc = RESET_PC; m_raddr = RESET_PC;
      m_req = 0; m_out = 0; m_stale = 0; m_err = 0;
      mb = 0; md = 0; ma = '0; ack_hold = 0;
      cyc_idx = 0; first_req = -1; first_val = -1;
      #1;
      chk("rst_mem_req", bus.mem_req, 32'h0);
      chk("rst_mem_addr", bus.mem_addr, RESET_PC);
      chk("rst_inst_valid", bus.inst_valid, 32'h0);
      chk("rst_inst", bus.inst, 32'h0);
      chk("rst_inst_pc", bus.inst_pc, 32'h0);
      chk("rst_misalign", bus.misalign_err, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   function automatic bit cond(input int w);
      case (w)
         0: return m_out && !m_stale && m_raddr == 32'h8;
         1: return m_req && !m_stale;
         2: return mq.size() == 3 && mb && md == 0;
         default: return !m_req && !m_out;
      endcase
   endfunction

   task automatic wait_for(input int w, input string nm);
      int n;
      n = 0;
      while (!cond(w) && n < 100) begin
         cycle(1'b0, 32'h0);
         n++;
      end
      chk(nm, 32'(n < 100), 32'h1);
   endtask

   task automatic knobs(input int a, input int d, input int r,
                        input int x);
      ack_pct = a; dmax = d; rdy_pct = r; redir_pct = x;
   endtask

   initial begin
      int          n;
      logic [31:0] exp_t;
      knobs(100, 0, 100, 0);
      @(negedge clk);

      // streaming from reset
      do_reset();
      run(12);
      chk("first_req_cycle", first_req, 32'd0);
      chk("first_valid_cycle", first_val, 32'd2);
      chk("ack0", acks_log[0], 32'h0);
      chk("ack1", acks_log[1], 32'h4);
      chk("ack2", acks_log[2], 32'h8);
      chk("pop0", pops_log[0], 32'h0);
      chk("pop1", pops_log[1], 32'h4);

      // decode stalled: queue fills, then one pop frees one slot
      do_reset();
      knobs(100, 0, 0, 0);
      run(30);
      chk("full_acks", acks_log.size(), 32'd4);
      rdy_pct = 100;
      cycle(1'b0, 32'h0);
      rdy_pct = 0;
      run(20);
      chk("refill_acks", acks_log.size(), 32'd5);
      chk("refill_addr", acks_log[4], 32'h10);

      // redirect while waiting on 0x8
      do_reset();
      knobs(100, 0, 100, 0);
      wait_for(0, "wait_on_8");
      n = acks_log.size();
      cycle(1'b1, 32'h100);
      chk("flush_valid", bus.inst_valid, 32'h0);
      pops_log.delete();
      run(20);
      chk("redir_ack", acks_log[n], 32'h100);
      chk("redir_pop", pops_log[0], 32'h100);

      // redirect during an unacked request
      do_reset();
      knobs(100, 0, 100, 0);
      wait_for(1, "req_state");
      n = acks_log.size();
      ack_hold = 4;
      cycle(1'b1, 32'h40);
      for (int i = 0; i < 3; i++) begin
         chk("stale_req", bus.mem_req, 32'h1);
         chk("stale_addr", bus.mem_addr, 32'h0);
         cycle(1'b0, 32'h0);
      end
      run(20);
      chk("stale_ack", acks_log[n], 32'h0);
      chk("target_ack", acks_log[n+1], 32'h40);

      // simultaneous pop and push at count 3
      do_reset();
      knobs(100, 0, 0, 0);
      wait_for(2, "count3_wait");
      rdy_pct = 100;
      cycle(1'b0, 32'h0);
      rdy_pct = 0;
      chk("pp_count", mq.size(), 32'd3);
      chk("pp_pop", pops_log[0], 32'h0);
      chk("pp_head", mq[0].pc, 32'h4);
      chk("pp_tail", mq[2].pc, 32'hC);
      chk("pp_dut_head", bus.inst_pc, 32'h4);

      // misaligned redirect from idle
      do_reset();
      knobs(100, 0, 0, 0);
      wait_for(3, "idle_state");
      acks_log.delete();
      cycle(1'b1, 32'h102);
      run(10);
      exp_t = ALIGN_EN ? 32'h100 : 32'h102;
      chk("align_ack", acks_log[0], exp_t);
      chk("align_err", bus.misalign_err, 32'(ALIGN_EN));

      // randomized traffic with periodic resets
      for (int b = 0; b < 20; b++) begin
         if (b % 5 == 0) do_reset();
         knobs($urandom_range(100, 30), $urandom_range(3),
               $urandom_range(100), $urandom_range(8));
         run(200);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
